// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand interlocks,
// multi-cycle EX sequencing and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_multi,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             mem_memread,
    input  logic [REG_W-1:0] mem_wreg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] MULTI = 1'b1;

    localparam int MW = $clog2(MULTI_LAT);
    localparam logic [MW-1:0] MSTART = MW'(MULTI_LAT - 2);

    logic [0:0]       state_q, state_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic m_ex, m_mem;
    logic load_use, br_ex, br_mem, stall;
    logic stall_cyc;

    // Register 0 is hardwired and never creates a dependency.
    function automatic logic match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             urs,
        input logic             urt
    );
        return (r != '0) && ((urs && (r == rs)) || (urt && (r == rt)));
    endfunction

    assign m_ex  = match(ex_wreg, id_rs, id_rt, id_uses_rs, id_uses_rt);
    assign m_mem = match(mem_wreg, id_rs, id_rt, id_uses_rs, id_uses_rt);

    assign load_use = id_valid && ex_memread && m_ex;
    assign br_ex    = id_valid && id_branch && ex_regwrite && m_ex;
    assign br_mem   = id_valid && id_branch && mem_memread && m_mem;
    assign stall    = load_use || br_ex || br_mem;

    assign stall_cyc = ((state_q == RUN) && stall) || (state_q == MULTI);

    // Next state: multi-cycle issue from RUN, countdown in MULTI.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            RUN: begin
                if (!stall && id_valid && id_multi) begin
                    state_d = MULTI;
                    mcnt_d  = MSTART;
                end
            end
            MULTI: begin
                if (mcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    mcnt_d = mcnt_q - MW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control outputs; held in the safe stalled pattern while in reset.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        busy        = 1'b0;
        if (Reset) begin
            if (state_q == MULTI) begin
                busy = 1'b1;
            end else if (!stall) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_bubble = 1'b0;
                ifid_flush  = jump || (id_branch && branch_taken);
            end
        end
    end

    // Saturating stall counter: sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_cyc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, multi-cycle countdown and counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            mcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table vectors plus multi-cycle
// sequences, checked through an expected-result queue.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       multi;
        logic       taken;
        logic       jump;
        logic       exrw;
        logic       exmr;
        logic [4:0] exw;
        logic       memmr;
        logic [4:0] memw;
    } in_t;

    // pw, iw, fl, bub, busy
    typedef struct packed {
        logic pw;
        logic iw;
        logic fl;
        logic bub;
        logic busy;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    typedef struct {
        string name;
        int    d;
        out_t  o;
        int    cnt;
    } exp_t;

    localparam out_t RUNO = 5'b11000;
    localparam out_t STLO = 5'b00010;
    localparam out_t FLO  = 5'b11100;
    localparam out_t BSYO = 5'b00011;

    logic Clk;
    logic Reset;
    in_t  c1, c2;

    logic pw1, iw1, fl1, bub1, busy1;
    logic pw2, iw2, fl2, bub2, busy2;
    logic [31:0] sc1;
    logic [3:0]  sc2;

    int   n_chk;
    int   n_fail;
    int   sc_m [2];
    exp_t sb [$];
    vec_t tbl [$];

    pipe_hazard_ctrl #(.REG_W(5), .MULTI_LAT(4), .CNT_W(32)) u1 (
        .Clk(Clk), .Reset(Reset),
        .id_valid(c1.valid), .id_rs(c1.rs), .id_rt(c1.rt),
        .id_uses_rs(c1.urs), .id_uses_rt(c1.urt),
        .id_branch(c1.br), .id_multi(c1.multi),
        .branch_taken(c1.taken), .jump(c1.jump),
        .ex_regwrite(c1.exrw), .ex_memread(c1.exmr), .ex_wreg(c1.exw),
        .mem_memread(c1.memmr), .mem_wreg(c1.memw),
        .pc_write(pw1), .ifid_write(iw1), .ifid_flush(fl1),
        .idex_bubble(bub1), .busy(busy1), .stall_count(sc1)
    );

    pipe_hazard_ctrl #(.REG_W(5), .MULTI_LAT(2), .CNT_W(4)) u2 (
        .Clk(Clk), .Reset(Reset),
        .id_valid(c2.valid), .id_rs(c2.rs), .id_rt(c2.rt),
        .id_uses_rs(c2.urs), .id_uses_rt(c2.urt),
        .id_branch(c2.br), .id_multi(c2.multi),
        .branch_taken(c2.taken), .jump(c2.jump),
        .ex_regwrite(c2.exrw), .ex_memread(c2.exmr), .ex_wreg(c2.exw),
        .mem_memread(c2.memmr), .mem_wreg(c2.memw),
        .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2),
        .idex_bubble(bub2), .busy(busy2), .stall_count(sc2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // A flush in the same cycle as a multi-cycle issue is illegal.
    always @(negedge Clk) begin
        if (Reset) begin
            assert (!(c1.valid && c1.multi && pw1 && fl1))
                else $error("illegal flush with multi issue (u1)");
            assert (!(c2.valid && c2.multi && pw2 && fl2))
                else $error("illegal flush with multi issue (u2)");
        end
    end

    function automatic out_t get_out(input int d);
        out_t r;
        if (d == 0) r = '{pw1, iw1, fl1, bub1, busy1};
        else        r = '{pw2, iw2, fl2, bub2, busy2};
        return r;
    endfunction

    function automatic int get_cnt(input int d);
        if (d == 0) return int'(sc1);
        return int'(sc2);
    endfunction

    function automatic int cnt_max(input int d);
        if (d == 0) return 32'h7fffffff;
        return 15;
    endfunction

    function automatic in_t idle();
        in_t t;
        t = '0;
        t.valid = 1'b1;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input string nm, input out_t e);
        exp_t x;
        x.name = nm;
        x.d    = d;
        x.o    = e;
        x.cnt  = sc_m[d];
        sb.push_back(x);
    endtask

    task automatic pop_cmp();
        exp_t x;
        out_t a;
        x = sb.pop_front();
        a = get_out(x.d);
        chk({x.name, "/pc_write"},    int'(a.pw),   int'(x.o.pw));
        chk({x.name, "/ifid_write"},  int'(a.iw),   int'(x.o.iw));
        chk({x.name, "/ifid_flush"},  int'(a.fl),   int'(x.o.fl));
        chk({x.name, "/idex_bubble"}, int'(a.bub),  int'(x.o.bub));
        chk({x.name, "/busy"},        int'(a.busy), int'(x.o.busy));
        chk({x.name, "/stall_count"}, get_cnt(x.d), x.cnt);
    endtask

    task automatic check_now(input int d, input string nm, input out_t e);
        push_exp(d, nm, e);
        pop_cmp();
    endtask

    // Drive one cycle of ID/EX/MEM state, check, then clock it in.
    task automatic apply(input int d, input string nm,
                         input in_t i, input out_t e);
        if (d == 0) c1 = i;
        else        c2 = i;
        #1;
        push_exp(d, nm, e);
        pop_cmp();
        @(posedge Clk);
        if (e.bub && Reset && sc_m[d] < cnt_max(d)) sc_m[d]++;
        @(negedge Clk);
    endtask

    task automatic add(input string nm, input in_t i, input out_t o);
        vec_t v;
        v.name = nm;
        v.i    = i;
        v.o    = o;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        in_t t;
        n_chk   = 0;
        n_fail  = 0;
        sc_m[0] = 0;
        sc_m[1] = 0;

        t = idle(); t.valid = 0; t.exmr = 1; t.exrw = 1;
        t.exw = 3; t.rs = 3; t.urs = 1;
        add("inval", t, RUNO);
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 3; t.rs = 3; t.urs = 1;
        add("lu_rs", t, STLO);
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 7; t.rt = 7; t.urt = 1;
        add("lu_rt", t, STLO);
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 0; t.rs = 0; t.urs = 1;
        add("lu_r0", t, RUNO);
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 3; t.rs = 3;
        add("lu_nouse", t, RUNO);
        t = idle(); t.exrw = 1; t.exw = 4; t.rs = 4; t.urs = 1;
        add("alu_fwd", t, RUNO);
        t = idle(); t.br = 1; t.taken = 1; t.exrw = 1; t.exw = 4;
        t.rt = 4; t.urt = 1;
        add("br_ex", t, STLO);
        t = idle(); t.br = 1; t.memmr = 1; t.memw = 6; t.rs = 6; t.urs = 1;
        add("br_mem", t, STLO);
        t = idle(); t.memmr = 1; t.memw = 6; t.rs = 6; t.urs = 1;
        add("mem_nobr", t, RUNO);
        t = idle(); t.jump = 1;
        add("jump", t, FLO);
        t = idle(); t.br = 1; t.taken = 1; t.rs = 2; t.urs = 1;
        add("br_tk", t, FLO);
        t = idle(); t.br = 1; t.rs = 2; t.urs = 1;
        add("br_nt", t, RUNO);
        t = idle(); t.br = 1; t.taken = 1; t.memw = 6; t.rs = 6; t.urs = 1;
        add("br_memalu", t, FLO);
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 9; t.rs = 3; t.rt = 4;
        t.urs = 1; t.urt = 1;
        add("lu_other", t, RUNO);
        t = idle(); t.br = 1; t.taken = 1; t.exrw = 1; t.exw = 0;
        t.rs = 0; t.urs = 1;
        add("br_ex_r0", t, FLO);

        // Reset held: outputs forced even with a jump presented.
        Reset = 1'b0;
        c1 = idle(); c1.jump = 1;
        c2 = idle();
        @(negedge Clk);
        #1;
        check_now(0, "rst_hold", STLO);
        check_now(1, "rst_hold2", STLO);
        Reset = 1'b1;

        foreach (tbl[k]) apply(0, tbl[k].name, tbl[k].i, tbl[k].o);

        // Load-use: exactly one stall, then the add proceeds.
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 3; t.rs = 3; t.urs = 1;
        apply(0, "lu_s1", t, STLO);
        t = idle(); t.memmr = 1; t.memw = 3; t.rs = 3; t.urs = 1;
        apply(0, "lu_go", t, RUNO);

        // Load feeding a taken branch: two stalls, then one flush.
        t = idle(); t.br = 1; t.taken = 1; t.rs = 5; t.urs = 1;
        t.exmr = 1; t.exrw = 1; t.exw = 5;
        apply(0, "lb_s1", t, STLO);
        t = idle(); t.br = 1; t.taken = 1; t.rs = 5; t.urs = 1;
        t.memmr = 1; t.memw = 5;
        apply(0, "lb_s2", t, STLO);
        t = idle(); t.br = 1; t.taken = 1; t.rs = 5; t.urs = 1;
        apply(0, "lb_flush", t, FLO);
        apply(0, "lb_after", idle(), RUNO);

        // Multi-cycle op, latency 4: issue then 3 busy cycles that
        // ignore both hazards and a jump in ID.
        t = idle(); t.multi = 1;
        apply(0, "m4_issue", t, RUNO);
        t = idle(); t.jump = 1; t.exmr = 1; t.exrw = 1;
        t.exw = 3; t.rs = 3; t.urs = 1;
        for (int k = 0; k < 3; k++) apply(0, "m4_busy", t, BSYO);
        apply(0, "m4_run", idle(), RUNO);

        // Reset asserted during the second MULTI cycle.
        t = idle(); t.multi = 1;
        apply(0, "mr_issue", t, RUNO);
        apply(0, "mr_b1", idle(), BSYO);
        c1 = idle();
        #1;
        check_now(0, "mr_b2", BSYO);
        #1;
        Reset = 1'b0;
        sc_m[0] = 0;
        sc_m[1] = 0;
        #1;
        check_now(0, "mr_rst", STLO);
        @(negedge Clk);
        #1;
        check_now(0, "mr_rst_hold", STLO);
        Reset = 1'b1;
        apply(0, "mr_rel1", idle(), RUNO);
        apply(0, "mr_rel2", idle(), RUNO);

        // Multi-cycle op, latency 2: a single busy cycle.
        t = idle(); t.multi = 1;
        apply(1, "m2_issue", t, RUNO);
        apply(1, "m2_busy", idle(), BSYO);
        apply(1, "m2_run", idle(), RUNO);

        // 4-bit counter saturates at 15 over 20 more stalls.
        t = idle(); t.exmr = 1; t.exrw = 1; t.exw = 8; t.rt = 8; t.urt = 1;
        for (int k = 0; k < 20; k++) apply(1, "sat", t, STLO);
        apply(1, "sat_hold", idle(), RUNO);
        chk("sat_final", int'(sc2), 15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage datapath. It replaces hard-wired forwarding-only operation with real interlocks. It detects load-use and branch-operand hazards and sequences multi-cycle execute ops. It drives PC/IF-ID write enables, IF-ID flush and the ID/EX bubble, and keeps a saturating stall-cycle counter.

Parameters:
REG_W, 5, register address width
MULTI_LAT, 4, total EX cycles of a multi-cycle op (>=2)
CNT_W, 32, width of stall-cycle performance counter

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_W  ID source register 1
id_rt  in  REG_W  ID source register 2
id_uses_rs  in  1  ID instruction reads id_rs
id_uses_rt  in  1  ID instruction reads id_rt
id_branch  in  1  ID instruction is a conditional branch (compared in ID)
id_multi  in  1  ID instruction is a multi-cycle EX op
branch_taken  in  1  ID compare result, taken
jump  in  1  ID instruction is an unconditional jump
ex_regwrite  in  1  ID/EX RegWrite
ex_memread  in  1  ID/EX MemRead
ex_wreg  in  REG_W  ID/EX destination register
mem_memread  in  1  EX/MEM MemRead
mem_wreg  in  REG_W  EX/MEM destination register
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP on next edge
idex_bubble  out  1  ID/EX loads NOP control (RegWrite=MemRead=0)
busy  out  1  multi-cycle op in progress
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Match(r) = (r != 0) and ((id_uses_rs and r == id_rs) or (id_uses_rt and r == id_rt)); register 0 never causes a hazard.
- Hazard terms, all gated by id_valid:
  - load_use: ex_memread and Match(ex_wreg).
  - br_ex: id_branch and ex_regwrite and Match(ex_wreg). Covers both ALU and load producers.
  - br_mem: id_branch and mem_memread and Match(mem_wreg).
  - stall = load_use or br_ex or br_mem.
- States: RUN, MULTI. The state register and down-counter mcnt (width ceil(log2(MULTI_LAT))) are registered. All other outputs are combinational from state and inputs.
- RUN, stall=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - branch_taken/jump are ignored this cycle. The branch re-evaluates once the stall clears.
  - A load feeding a branch in ID therefore costs 2 cycles (br_ex, then br_mem).
- RUN, stall=0:
  - pc_write=1, ifid_write=1, idex_bubble=0.
  - ifid_flush = jump or (id_branch and branch_taken).
  - If id_multi: the op issues to ID/EX this cycle, next state is MULTI, mcnt <= MULTI_LAT-2.
- MULTI:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, busy=1.
  - ID-stage hazard terms are ignored.
  - If mcnt==0, next state is RUN; else mcnt decrements.
  - Net effect: exactly MULTI_LAT-1 bubble cycles after issue.
- busy=1 only in MULTI.
- Flush and multi issue together (a jump cannot be id_multi) is illegal; behaviour is undefined and a bench assertion flags it.
- stall_count increments on each rising edge where (RUN and stall) or MULTI. It holds at all-ones; it never wraps.
- Reset low, any time including mid-MULTI:
  - state=RUN, mcnt=0, stall_count=0.
  - While Reset is low, outputs are forced: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, busy=0.
  - After Reset rises, the first edge behaves as RUN.
- No internal latency beyond the above: hazard outputs respond in the same cycle the inputs present.

Test Plan:
- lw r3 in EX (ex_memread=1, ex_wreg=3); ID add with rs=3, uses_rs=1 -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1; next cycle pc_write=1; stall_count=1.
- Same, but ex_wreg=0 and id_rs=0 -> no stall; pc_write=1 every cycle; stall_count stays 0.
- lw r5 then beq rs=5 with branch_taken=1 asserted throughout -> 2 stall cycles, no flush during them; on cycle 3 ifid_flush=1 for one cycle; stall_count=2.
- id_multi=1 with MULTI_LAT=4 -> issue cycle has idex_bubble=0, then 3 cycles of busy=1 with idex_bubble=1, then RUN; repeat with MULTI_LAT=2 -> 1 busy cycle.
- jump with no hazard -> ifid_flush=1, pc_write=1 same cycle; idex_bubble=0.
- Reset driven low during the 2nd MULTI cycle -> outputs immediately forced to reset values, busy=0, stall_count=0; after release, a non-hazard instruction gives pc_write=1 on the first edge. Also force stall_count to all-ones with CNT_W=4 over 20 stall cycles -> it holds at 15.
